// File: rtl/regfile_seq_ctrl.sv
// Streams words into (LOAD) or out of (DUMP) consecutive RegisterFile addresses.
// Optional RFSEQ_CHECKSUM_EN adds a running XOR of every transferred word.
module regfile_seq_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_wrtAddr,
  output logic [DATA_W-1:0] rf_wrtData,
  output logic              rf_wrtEnable,
  output logic [ADDR_W-1:0] rf_rdAddr1,
  input  logic [DATA_W-1:0] rf_rdData1
`ifdef RFSEQ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StDump, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   cnt_q;

  logic            start_fire;
  logic            load_fire;
  logic            dump_fire;
  logic            last_word;
  logic [ADDR_W:0] len_eff;

  assign len_eff    = (len == '0) ? (ADDR_W + 1)'(NUM_REGS) : len;
  assign start_fire = (state_q == StIdle) && (start_load || start_dump);
  assign load_fire  = (state_q == StLoad) && in_valid && in_ready;
  assign dump_fire  = out_valid && out_ready;
  assign last_word  = (cnt_q == (ADDR_W + 1)'(1));

  // Read path is combinational; the pointer only moves on a handshake, so data holds.
  assign rf_rdAddr1 = ptr_q;
  assign out_data   = out_valid ? rf_rdData1 : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cnt_q        <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rf_wrtAddr   <= '0;
      rf_wrtData   <= '0;
      rf_wrtEnable <= 1'b0;
    end else begin
      done         <= 1'b0;
      rf_wrtEnable <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_fire) begin
            ptr_q <= start_addr;
            cnt_q <= len_eff;
            busy  <= 1'b1;
            if (start_load) begin
              state_q  <= StLoad;
              in_ready <= 1'b1;
            end else begin
              state_q   <= StDump;
              out_valid <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (load_fire) begin
            rf_wrtEnable <= 1'b1;
            rf_wrtAddr   <= ptr_q;
            rf_wrtData   <= in_data;
            ptr_q        <= ptr_q + ADDR_W'(1);
            cnt_q        <= cnt_q - (ADDR_W + 1)'(1);
            if (last_word) begin
              state_q  <= StDone;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        StDump: begin
          if (dump_fire) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            cnt_q <= cnt_q - (ADDR_W + 1)'(1);
            if (last_word) begin
              state_q   <= StDone;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef RFSEQ_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (start_fire) begin
      checksum <= '0;
    end else if (load_fire) begin
      checksum <= checksum ^ in_data;
    end else if (dump_fire) begin
      checksum <= checksum ^ out_data;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Scoreboard bench for regfile_seq_ctrl with a behavioural 8x16 register file.
// Build with RFSEQ_CHECKSUM_EN defined to also exercise the checksum output.
module tb_regfile_seq_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_load = 1'b0, start_dump = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_ready = 1'b0, busy, done;
  logic [DW-1:0] out_data, rf_wrtData, rf_rdData1;
  logic [AW-1:0] rf_wrtAddr, rf_rdAddr1;
  logic          rf_wrtEnable;
`ifdef RFSEQ_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  regfile_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .start_load(start_load), .start_dump(start_dump),
    .start_addr(start_addr), .len(len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .rf_wrtAddr(rf_wrtAddr), .rf_wrtData(rf_wrtData),
    .rf_wrtEnable(rf_wrtEnable), .rf_rdAddr1(rf_rdAddr1), .rf_rdData1(rf_rdData1)
`ifdef RFSEQ_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Register file model: combinational read, write at the edge
  logic [DW-1:0] mem [NR];
  logic          preload = 1'b0;
  assign rf_rdData1 = mem[rf_rdAddr1];
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < NR; k++) mem[k] <= DW'(16'h1111 * k);
    end else if (rf_wrtEnable) begin
      mem[rf_wrtAddr] <= rf_wrtData;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] wr_q[$];
  logic [DW-1:0]    rd_q[$];
  logic [AW+DW-1:0] wr_e;
  logic [DW-1:0]    words[NR];
  int               busy_drop;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_q.push_back({a, d});
  endtask

  // Monitor: every write pulse and every valid dump word is matched against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_wrtEnable) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 32'd1, 32'd0);
        end else begin
          wr_e = wr_q.pop_front();
          chk("wr_addr", 32'(rf_wrtAddr), 32'(wr_e[AW+DW-1:DW]));
          chk("wr_data", 32'(rf_wrtData), 32'(wr_e[DW-1:0]));
        end
      end
      if (out_valid) begin
        if (rd_q.size() == 0) begin
          chk("dump_unexpected", 32'd1, 32'd0);
        end else begin
          chk("dump_data", 32'(out_data), 32'(rd_q[0]));
          if (out_ready) void'(rd_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle command; returns one cycle after it was sampled
  task automatic start(input bit ld, input bit dp, input logic [AW-1:0] a, input logic [AW:0] l);
    tick();
    start_load = ld;
    start_dump = dp;
    start_addr = a;
    len        = l;
    tick();
    start_load = 1'b0;
    start_dump = 1'b0;
  endtask

  // Offers words[0..n-1] with in_valid held high until done; returns in the cycle after done
  task automatic send_words(input int n, input int bound, input string nm);
    int  idx;
    bit  seen;
    idx       = 0;
    seen      = 1'b0;
    busy_drop = 0;
    for (int c = 0; c < bound && !seen; c++) begin
      in_valid = (idx < n);
      in_data  = (idx < n) ? words[idx] : '0;
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (!busy) busy_drop++;
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid = 1'b0;
    chk(nm, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int bound, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  int  dcyc, pulses, blow, hs, lhs, we_cnt, consec;
  bit  prev_we;
  logic [5:0] pat;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wr_en", 32'(rf_wrtEnable), 32'd0);
    chk("rst_wr_addr", 32'(rf_wrtAddr), 32'd0);
    chk("rst_wr_data", 32'(rf_wrtData), 32'd0);
    chk("rst_rd_addr", 32'(rf_rdAddr1), 32'd0);
    #2 rst = 1'b0;

    // Reset mid-LOAD: only the first accepted word ever reaches the write port
    push_wr(3'd0, 16'hB001);
    start(1'b1, 1'b0, 3'd0, 4'd5);
    in_valid = 1'b1;
    in_data  = 16'hB001;
    tick();
    in_data  = 16'hB002;
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_en", 32'(rf_wrtEnable), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    chk("midrst_wr_q_empty", 32'(wr_q.size()), 32'd0);

    // LOAD with address wrap, in_valid held high
    push_wr(3'd6, 16'hA001);
    push_wr(3'd7, 16'hA002);
    push_wr(3'd0, 16'hA003);
    push_wr(3'd1, 16'hA004);
    start(1'b1, 1'b0, 3'd6, 4'd4);
    dcyc = 0; pulses = 0; blow = 0;
    for (int k = 1; k <= 6; k++) begin
      in_valid = (k <= 4);
      in_data  = (k <= 4) ? DW'(16'hA000 + k) : '0;
      @(negedge clk);
      if (done) begin
        pulses++;
        if (dcyc == 0) dcyc = k;
      end
      if (k <= 5 && !busy) blow++;
      if (k == 6) chk("wrap_idle_busy", 32'(busy), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("wrap_done_cycle", 32'(dcyc), 32'd5);
    chk("wrap_done_pulses", 32'(pulses), 32'd1);
    chk("wrap_busy_low", 32'(blow), 32'd0);
    chk("wrap_wr_q_empty", 32'(wr_q.size()), 32'd0);

    // Read the wrapped block back
    for (int k = 1; k <= 4; k++) rd_q.push_back(DW'(16'hA000 + k));
    out_ready = 1'b1;
    start(1'b0, 1'b1, 3'd6, 4'd4);
    wait_done(20, "wrap_dump_done");
    chk("wrap_dump_q_empty", 32'(rd_q.size()), 32'd0);

    // Full DUMP (len 0) with out_ready toggling
    tick();
    preload = 1'b1;
    tick();
    preload = 1'b0;
    for (int k = 0; k < NR; k++) rd_q.push_back(DW'(16'h1111 * k));
    out_ready = 1'b1;
    start(1'b0, 1'b1, 3'd0, 4'd0);
    dcyc = 0; hs = 0; lhs = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        dcyc = c;
        break;
      end
      if (out_valid && out_ready) begin
        hs++;
        lhs = c;
      end
      tick();
      out_ready = !out_ready;
    end
    chk("full_dump_done_seen", 32'(dcyc != 0), 32'd1);
    chk("full_dump_handshakes", 32'(hs), 32'd8);
    chk("full_dump_done_after_last", 32'(dcyc), 32'(lhs + 1));
    chk("full_dump_q_empty", 32'(rd_q.size()), 32'd0);
    out_ready = 1'b1;

    // LOAD with gaps in in_valid
    push_wr(3'd2, 16'hC001);
    push_wr(3'd3, 16'hC002);
    push_wr(3'd4, 16'hC003);
    start(1'b1, 1'b0, 3'd2, 4'd3);
    pat = 6'b101001;
    we_cnt = 0; consec = 0; prev_we = 1'b0; pulses = 0;
    begin
      int wi;
      wi = 0;
      for (int k = 0; k < 10; k++) begin
        in_valid = (k < 6) ? pat[k] : 1'b0;
        in_data  = in_valid ? DW'(16'hC001 + wi) : '0;
        if (in_valid) wi++;
        @(negedge clk);
        if (rf_wrtEnable) we_cnt++;
        if (rf_wrtEnable && prev_we) consec++;
        prev_we = rf_wrtEnable;
        if (done) pulses++;
        tick();
      end
    end
    in_valid = 1'b0;
    chk("gap_wr_pulses", 32'(we_cnt), 32'd3);
    chk("gap_wr_back_to_back", 32'(consec), 32'd0);
    chk("gap_done_pulses", 32'(pulses), 32'd1);

    // Simultaneous start_load/start_dump enters LOAD; a later start_dump is ignored
    push_wr(3'd0, 16'hD001);
    push_wr(3'd1, 16'hD002);
    start(1'b1, 1'b1, 3'd0, 4'd2);
    #3;
    chk("collide_in_ready", 32'(in_ready), 32'd1);
    chk("collide_out_valid", 32'(out_valid), 32'd0);
    start_dump = 1'b1;
    start_addr = 3'd5;
    len        = 4'd1;
    words[0] = 16'hD001;
    words[1] = 16'hD002;
    tick();
    start_dump = 1'b0;
    send_words(2, 20, "collide_done");
    chk("collide_busy_drop", 32'(busy_drop), 32'd0);
    @(negedge clk);
    chk("collide_idle_after", 32'(busy), 32'd0);
    chk("collide_wr_q_empty", 32'(wr_q.size()), 32'd0);

`ifdef RFSEQ_CHECKSUM_EN
    push_wr(3'd0, 16'h00FF);
    push_wr(3'd1, 16'h0F0F);
    push_wr(3'd2, 16'h1234);
    words[0] = 16'h00FF;
    words[1] = 16'h0F0F;
    words[2] = 16'h1234;
    start(1'b1, 1'b0, 3'd0, 4'd3);
    send_words(3, 20, "csum_load_done");
    #3;
    chk("csum_after_load", 32'(checksum), 32'(16'h00FF ^ 16'h0F0F ^ 16'h1234));
    out_ready = 1'b0;
    rd_q.push_back(16'h00FF);
    start(1'b0, 1'b1, 3'd0, 4'd1);
    #3;
    chk("csum_cleared_on_start", 32'(checksum), 32'd0);
    out_ready = 1'b1;
    wait_done(10, "csum_dump_done");
    #6;
    chk("csum_after_dump", 32'(checksum), 32'h00FF);
`endif

    repeat (3) tick();
    chk("final_wr_q_empty", 32'(wr_q.size()), 32'd0);
    chk("final_rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
